// File: rtl/dither_pkg.sv
// Shared defaults and the FIFO entry type for the dither packing stage.
package dither_pkg;

  localparam int unsigned WORD_W_DEF   = 8;
  localparam int unsigned H_ACTIVE_DEF = 320;
  localparam int unsigned V_ACTIVE_DEF = 240;
  localparam int unsigned HCNT_W       = 11;
  localparam int unsigned VCNT_W       = 10;
  localparam int unsigned ADDR_W_DEF   = 14;

  // Packed word with its frame-buffer address, at the default geometry.
  typedef struct packed {
    logic [WORD_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] addr;
    logic                  last;
  } pkt_t;

endpackage

// File: rtl/dither_packer_if.sv
// Valid/ready bus carrying packed words towards the frame-store writer.
interface dither_packer_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 14
);
  logic [WORD_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, out_addr, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_addr, out_last, out_valid, output out_ready);
endinterface

// File: rtl/packer_fifo2.sv
// Two-entry valid/ready FIFO with a registered head; reports pushes lost while full.
module packer_fifo2
  import dither_pkg::*;
#(
  parameter type entry_t = pkt_t
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop_ready,
  output entry_t head,
  output logic   head_valid,
  output logic   drop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ONE  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       pop;

  assign head_valid = (state_q != ST_IDLE);
  assign head       = head_q;
  assign pop        = head_valid && pop_ready;

  // Next-state: occupancy follows push/pop; a same-cycle push at count 1 replaces the head.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    drop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          head_d  = push_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            state_d = ST_ONE;
          end
        end else if (push) begin
          drop = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset zeroes the head so outputs read 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/dither_packer.sv
// Packs the 1-bit dithered pixel stream into row-aligned words with frame-buffer addresses.
module dither_packer
  import dither_pkg::*;
#(
  parameter int unsigned WORD_W   = WORD_W_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              dithered_pixel,
  input  logic [HCNT_W-1:0] dithered_hcount,
  input  logic [VCNT_W-1:0] dithered_vcount,
  input  logic              dithered_valid,
  dither_packer_if.master   out_bus,
  output logic              overflow
);

  localparam int unsigned WORDS_PER_ROW = (H_ACTIVE + WORD_W - 1) / WORD_W;
  localparam int unsigned ADDR_W        = $clog2(WORDS_PER_ROW * V_ACTIVE);
  localparam int unsigned IDX_W         = $clog2(WORD_W);

  localparam logic [HCNT_W:0]   H_LIMIT  = (HCNT_W + 1)'(H_ACTIVE);
  localparam logic [VCNT_W:0]   V_LIMIT  = (VCNT_W + 1)'(V_ACTIVE);
  localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_ACTIVE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = {IDX_W{1'b1}};

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } word_t;

  logic [WORD_W-1:0] acc_q, acc_d;
  logic              skip_q, skip_d;
  logic              overflow_q;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              word_done;
  logic              push;
  logic              drop;
  word_t             push_word;
  word_t             head;
  logic              head_valid;

  assign idx    = dithered_hcount[IDX_W-1:0];
  assign accept = dithered_valid
                  && ({1'b0, dithered_hcount} < H_LIMIT)
                  && ({1'b0, dithered_vcount} < V_LIMIT);

  // Accumulate the pixel into its bit slot; bit 0 restarts the word with the rest cleared.
  // skip_q suppresses a word whose start was lost to reset, until the next word boundary.
  always_comb begin
    acc_d     = acc_q;
    skip_d    = skip_q;
    word_done = 1'b0;
    if (accept) begin
      if (idx == '0) begin
        acc_d  = '0;
        skip_d = 1'b0;
      end
      acc_d[idx] = dithered_pixel;
      word_done  = (idx == IDX_LAST) || (dithered_hcount == H_LAST);
    end
  end

  assign push = word_done && !(skip_q && (idx != '0));

  assign push_word.data = acc_d;
  assign push_word.addr = ADDR_W'(dithered_vcount) * ADDR_W'(WORDS_PER_ROW)
                          + ADDR_W'(dithered_hcount >> IDX_W);
  assign push_word.last = (dithered_hcount == H_LAST) && (dithered_vcount == V_LAST);

  // Accumulator, resync flag and sticky overflow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q      <= '0;
      skip_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      skip_q <= skip_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  packer_fifo2 #(
    .entry_t (word_t)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (push),
    .push_data  (push_word),
    .pop_ready  (out_bus.out_ready),
    .head       (head),
    .head_valid (head_valid),
    .drop       (drop)
  );

  assign out_bus.out_data  = head.data;
  assign out_bus.out_addr  = head.addr;
  assign out_bus.out_last  = head.last;
  assign out_bus.out_valid = head_valid;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_dither_packer.sv
// Scoreboard bench: stimulus queues expected words, per-DUT monitors pop and compare.
module tb_dither_packer;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default geometry. DUT B: 20x4 frame, partial last word per row.
  logic        pix_a = 0, val_a = 0, pix_b = 0, val_b = 0;
  logic [10:0] hc_a = 0, hc_b = 0;
  logic [9:0]  vc_a = 0, vc_b = 0;
  logic        ovf_a, ovf_b;

  dither_packer_if #(.WORD_W(8), .ADDR_W(14)) if_a ();
  dither_packer_if #(.WORD_W(8), .ADDR_W(4))  if_b ();

  dither_packer dut_a (
    .clk_in          (clk),
    .rst_in          (rst),
    .dithered_pixel  (pix_a),
    .dithered_hcount (hc_a),
    .dithered_vcount (vc_a),
    .dithered_valid  (val_a),
    .out_bus         (if_a),
    .overflow        (ovf_a)
  );

  dither_packer #(.H_ACTIVE(20), .V_ACTIVE(4)) dut_b (
    .clk_in          (clk),
    .rst_in          (rst),
    .dithered_pixel  (pix_b),
    .dithered_hcount (hc_b),
    .dithered_vcount (vc_b),
    .dithered_valid  (val_b),
    .out_bus         (if_b),
    .overflow        (ovf_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void ea(input logic [31:0] d, input logic [31:0] a, input logic l);
    qa.push_back('{data: d, addr: a, last: l});
  endfunction

  function automatic void eb(input logic [31:0] d, input logic [31:0] a, input logic l);
    qb.push_back('{data: d, addr: a, last: l});
  endfunction

  // Monitors: every accepted word must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && if_a.out_valid && if_a.out_ready) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL mon_a unexpected: data=%0h addr=%0d last=%0b",
                 if_a.out_data, if_a.out_addr, if_a.out_last);
      end else begin
        exp_t e;
        e = qa.pop_front();
        if ({24'd0, if_a.out_data} !== e.data || {18'd0, if_a.out_addr} !== e.addr
            || if_a.out_last !== e.last) begin
          n_bad++;
          $display("FAIL mon_a word: got data=%0h addr=%0d last=%0b want data=%0h addr=%0d last=%0b",
                   if_a.out_data, if_a.out_addr, if_a.out_last, e.data, e.addr, e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if_b.out_valid && if_b.out_ready) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL mon_b unexpected: data=%0h addr=%0d last=%0b",
                 if_b.out_data, if_b.out_addr, if_b.out_last);
      end else begin
        exp_t e;
        e = qb.pop_front();
        if ({24'd0, if_b.out_data} !== e.data || {28'd0, if_b.out_addr} !== e.addr
            || if_b.out_last !== e.last) begin
          n_bad++;
          $display("FAIL mon_b word: got data=%0h addr=%0d last=%0b want data=%0h addr=%0d last=%0b",
                   if_b.out_data, if_b.out_addr, if_b.out_last, e.data, e.addr, e.last);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic px_a(input logic p, input int hc, input int vc, input logic v);
    pix_a = p;
    hc_a  = 11'(hc);
    vc_a  = 10'(vc);
    val_a = v;
    cyc();
  endtask

  task automatic px_b(input logic p, input int hc, input int vc);
    pix_b = p;
    hc_b  = 11'(hc);
    vc_b  = 10'(vc);
    val_b = 1'b1;
    cyc();
  endtask

  task automatic idle(input int n);
    val_a = 1'b0;
    val_b = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) cyc();
    chk({name, "_qa_empty"}, qa.size(), 0);
    chk({name, "_qb_empty"}, qb.size(), 0);
  endtask

  initial begin
    logic [7:0] t1_pix;
    t1_pix = 8'b1000_1101;  // hcount 7..0
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", if_a.out_valid, 0);
    chk("rst_data", if_a.out_data, 0);
    chk("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    cyc();

    // Single word 0x8D at address 0, valid one cycle after hcount 7.
    ea(32'h8D, 0, 1'b0);
    for (int h = 0; h < 7; h++) px_a(t1_pix[h], h, 0, 1'b1);
    chk("t1_valid_early", if_a.out_valid, 0);
    px_a(t1_pix[7], 7, 0, 1'b1);
    chk("t1_valid_lat", if_a.out_valid, 1);
    idle(1);
    chk("t1_valid_gone", if_a.out_valid, 0);

    // Narrow DUT: 20-pixel row, last word zero-padded; last flag on final frame word.
    eb(32'hFF, 6, 1'b0);
    eb(32'hFF, 7, 1'b0);
    eb(32'h0F, 8, 1'b0);
    for (int h = 0; h < 20; h++) px_b(1'b1, h, 2);
    px_b(1'b1, 20, 2);
    px_b(1'b1, 23, 2);
    eb(32'h0F, 11, 1'b1);
    for (int h = 16; h < 20; h++) px_b(1'b1, h, 3);
    idle(2);
    drain("t2");

    // Ignored pixels leave no trace in the accumulator.
    ea(32'h65, 41, 1'b0);
    px_a(1'b1, 8, 1, 1'b1);
    px_a(1'b0, 9, 1, 1'b1);
    px_a(1'b1, 10, 1, 1'b1);
    px_a(1'b0, 11, 1, 1'b1);
    px_a(1'b1, 12, 1, 1'b0);
    px_a(1'b1, 400, 1, 1'b1);
    px_a(1'b0, 8, 300, 1'b1);
    px_a(1'b1, 407, 1, 1'b1);
    chk("t5_no_valid", if_a.out_valid, 0);
    px_a(1'b0, 12, 1, 1'b1);
    px_a(1'b1, 13, 1, 1'b1);
    px_a(1'b1, 14, 1, 1'b1);
    px_a(1'b0, 15, 1, 1'b1);
    idle(2);
    drain("t5");

    // Backpressure: two words held, third dropped, overflow sticks.
    if_a.out_ready = 1'b0;
    ea(32'hFF, 120, 1'b0);
    ea(32'hAA, 121, 1'b0);
    for (int h = 0; h < 8; h++) px_a(1'b1, h, 3, 1'b1);
    for (int h = 8; h < 16; h++) px_a(h[0], h, 3, 1'b1);
    chk("t4_head_hold1", if_a.out_data, 32'hFF);
    chk("t4_ovf_clear", ovf_a, 0);
    for (int h = 16; h < 24; h++) px_a(1'b0, h, 3, 1'b1);
    chk("t4_ovf_set", ovf_a, 1);
    chk("t4_head_hold2", if_a.out_data, 32'hFF);
    idle(3);
    chk("t4_head_hold3", if_a.out_addr, 120);
    chk("t4_ovf_sticky", ovf_a, 1);
    if_a.out_ready = 1'b1;
    idle(3);
    drain("t4");
    chk("t4_drained", if_a.out_valid, 0);
    chk("t4_ovf_after", ovf_a, 1);

    // Reset mid-word discards it; outputs read 0 right after.
    for (int h = 0; h < 4; h++) px_a(1'b1, h, 5, 1'b1);
    val_a = 1'b0;
    rst   = 1'b1;
    cyc();
    chk("t6_valid", if_a.out_valid, 0);
    chk("t6_data", if_a.out_data, 0);
    chk("t6_addr", if_a.out_addr, 0);
    chk("t6_last", if_a.out_last, 0);
    chk("t6_ovf", ovf_a, 0);
    rst = 1'b0;
    for (int h = 4; h < 8; h++) px_a(1'b1, h, 5, 1'b1);
    idle(2);
    chk("t6_no_word", if_a.out_valid, 0);

    // Full frame of ones.
    for (int v = 0; v < 240; v++) begin
      for (int h = 0; h < 320; h++) begin
        if (h % 8 == 7) ea(32'hFF, 32'(v * 40 + h / 8), (h == 319 && v == 239));
        px_a(1'b1, h, v, 1'b1);
      end
    end
    idle(2);
    drain("t3");
    chk("t3_ovf", ovf_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
